mem_master: RTL
===============

Name: mem_master

Overview:
- Bus initiator for the 8-bit synchronous RAM port: address in, write data in, read data out, write-enable.
- Accepts single-byte write requests and 1..2^LEN_W byte read-burst requests from the CPU core through a valid/ready handshake.
- Sequences the RAM port cycle by cycle and returns read bytes on a registered response stream.
- Sits between the CPU fetch/execute logic and the RAM.

Parameters:
- LEN_W, 2, width of req_len; maximum burst is 2^LEN_W bytes (4 by default).

Ports:
- clock  in  1  system clock; all logic on the posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = single-byte write, 0 = read burst.
- req_adrs  in  8  start address.
- req_wdata  in  8  write data; ignored for reads.
- req_len  in  LEN_W  read burst length minus one; ignored for writes.
- rsp_valid  out  1  rsp_data holds a read byte this cycle.
- rsp_data  out  8  read byte.
- rsp_last  out  1  final byte of the burst; qualified by rsp_valid.
- wr_ack  out  1  one-cycle pulse: write committed.
- ram_adrs  out  8  to RAM address input.
- ram_data  out  8  to RAM write-data input.
- ram_wr_en  out  1  to RAM write enable.
- ram_q  in  8  from RAM read data.

Behaviour:
- RAM timing contract:
  - The RAM latches address and write on the negedge.
  - ram_q is valid from that negedge until the next one.
  - All ram_* outputs are registered on the posedge.
  - ram_q is sampled on the following posedge.
  - Result: one byte per cycle, read latency of 1 cycle from address drive.
- Reset (asynchronous, reset_n=0):
  - State=IDLE.
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_last=0, wr_ack=0.
  - ram_adrs=0, ram_data=0, ram_wr_en=0.
  - Counter=0.
- FSM state IDLE:
  - req_ready=1.
  - Request accepted at posedge T when req_valid&req_ready.
- Write accept (at T):
  - ram_adrs<=req_adrs, ram_data<=req_wdata, ram_wr_en<=1; go to WRITE.
  - The RAM commits at the negedge after T.
- FSM state WRITE:
  - req_ready=0.
  - At T+1: ram_wr_en<=0, wr_ack<=1 for exactly one cycle, go to IDLE.
  - Minimum write spacing: 2 cycles.
- Read accept (at T):
  - ram_adrs<=req_adrs, remaining<=req_len, ram_wr_en stays 0; go to READ.
- FSM state READ:
  - req_ready=0.
  - Each posedge: rsp_data<=ram_q, rsp_valid<=1.
  - If remaining==0: rsp_last<=1 and go to IDLE.
  - Otherwise: ram_adrs<=ram_adrs+1 (mod 256) and remaining<=remaining-1.
- Burst output timing (N=req_len+1 bytes):
  - rsp_valid is high for the N cycles after edges T+1..T+N.
  - rsp_last is high only in the Nth of those cycles.
  - req_ready returns high after edge T+N, concurrent with the last byte.
  - A new request may therefore be accepted at T+N+1.
- rsp_valid/rsp_last/wr_ack drop to 0 on the next edge unless reasserted. There is no response backpressure; the consumer must take bytes as presented.
- Address wrap: a burst starting at 8'hFE with length 4 reads FE, FF, 00, 01.
- ram_wr_en is never 1 in IDLE or READ. ram_data holds its last write value during reads.
- Requests arriving while req_ready=0 are not accepted; the requester holds them.
- Reset mid-burst or mid-write:
  - All outputs return to reset values immediately.
  - No rsp_last and no wr_ack are issued.
  - A write whose negedge has not yet occurred is lost.
- req_len is sampled only at accept; later changes have no effect.

Test Plan:
1. Reset, then write 8'h5A to 8'h10 → ram_wr_en=1 for one cycle with ram_adrs=10, ram_data=5A; wr_ack pulses the next cycle; RAM[10]=5A.
2. Preload RAM[00..03]=01,07,06,22; read burst at 00 with req_len=3 → rsp_data 01,07,06,22 on 4 consecutive cycles; rsp_last only with 22; req_ready low for 4 cycles.
3. Single read at 8'h07 (req_len=0) with RAM[07]=03 → one rsp_valid cycle, data 03, rsp_last=1, starting 1 cycle after accept.
4. Read burst at 8'hFE with req_len=3 → addresses FE,FF,00,01 driven; 4 bytes returned in order.
5. Back-to-back: write 8'hAA to 20, then immediately hold a read of 20 → read accepted only after the WRITE state; returns AA; ram_wr_en never asserted during the read.
6. Assert reset_n=0 during the 2nd byte of a 4-byte burst → rsp_valid/rsp_last/req_ready/ram_* at reset values at once; after release, a new read completes correctly.

Source files
------------

// File: rtl/mem_master.sv
`timescale 1ns/1ps
// mem_master
//
// Bus initiator for an 8-bit synchronous RAM port. It accepts single-byte
// writes and 1..2^LEN_W byte read bursts from the CPU core over a valid/ready
// handshake. It drives the RAM port one cycle at a time and returns read bytes
// on a registered response stream.
//
// RAM timing seen by this block:
//   - ram_* outputs change on the posedge.
//   - The RAM latches address and write on the following negedge.
//   - ram_q is valid from that negedge on and is sampled on the next posedge.
//   - A read therefore returns one byte per cycle, one cycle after the
//     address is driven.
//
// State table:
//   state | meaning
//   IDLE  | req_ready high; a request is taken on req_valid
//   WRITE | write strobe on the RAM port this cycle; wr_ack follows
//   READ  | one byte captured per cycle until remaining reaches zero
//
// Ports:
//   clock      in   system clock; all logic on the posedge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  block can accept a request (high exactly in IDLE)
//   req_write  in   1 = single-byte write, 0 = read burst
//   req_adrs   in   start address
//   req_wdata  in   write data (writes only)
//   req_len    in   read burst length minus one (reads only)
//   rsp_valid  out  rsp_data holds a read byte this cycle
//   rsp_data   out  read byte
//   rsp_last   out  final byte of the burst, qualified by rsp_valid
//   wr_ack     out  one-cycle pulse: write committed
//   ram_adrs   out  RAM address
//   ram_data   out  RAM write data
//   ram_wr_en  out  RAM write enable
//   ram_q      in   RAM read data

module mem_master #(
    parameter int LEN_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [7:0]       req_adrs,
    input  logic [7:0]       req_wdata,
    input  logic [LEN_W-1:0] req_len,
    output logic             rsp_valid,
    output logic [7:0]       rsp_data,
    output logic             rsp_last,
    output logic             wr_ack,
    output logic [7:0]       ram_adrs,
    output logic [7:0]       ram_data,
    output logic             ram_wr_en,
    input  logic [7:0]       ram_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   remaining_nxt;
    logic [7:0]         adrs_nxt;
    logic [7:0]         data_nxt;
    logic               wr_en_nxt;
    logic [7:0]         rsp_data_nxt;
    logic               rsp_valid_nxt;
    logic               rsp_last_nxt;
    logic               wr_ack_nxt;

    // Ready is decoded from state so it rises on the same edge that delivers
    // the last burst byte or the write acknowledge.
    assign req_ready = (state == IDLE);

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        adrs_nxt      = ram_adrs;
        data_nxt      = ram_data;   // holds the last written value during reads
        wr_en_nxt     = 1'b0;
        rsp_data_nxt  = rsp_data;
        rsp_valid_nxt = 1'b0;
        rsp_last_nxt  = 1'b0;
        wr_ack_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    adrs_nxt = req_adrs;
                    if (req_write) begin
                        data_nxt  = req_wdata;
                        wr_en_nxt = 1'b1;
                        state_nxt = WRITE;
                    end else begin
                        remaining_nxt = req_len;
                        state_nxt     = READ;
                    end
                end
            end

            WRITE: begin
                // The RAM committed the write on the negedge just passed.
                wr_ack_nxt = 1'b1;
                state_nxt  = IDLE;
            end

            READ: begin
                rsp_data_nxt  = ram_q;
                rsp_valid_nxt = 1'b1;
                if (remaining == '0) begin
                    rsp_last_nxt = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    adrs_nxt      = ram_adrs + 8'd1;    // wraps FF -> 00
                    remaining_nxt = remaining - LEN_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            ram_adrs  <= 8'h00;
            ram_data  <= 8'h00;
            ram_wr_en <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            wr_ack    <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            ram_adrs  <= adrs_nxt;
            ram_data  <= data_nxt;
            ram_wr_en <= wr_en_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_last  <= rsp_last_nxt;
            wr_ack    <= wr_ack_nxt;
        end
    end

endmodule
